// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// Holds the FSM state, next-PC select encoding and default vectors.
package pc_gen_pkg;

    typedef enum logic {
        StBoot,
        StRun
    } state_e;

    typedef enum logic [2:0] {
        SelHold,
        SelSeq,
        SelTrap,
        SelMisalign,
        SelMret,
        SelRedirect
    } next_sel_e;

    localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
    localparam logic [31:0] DefaultTrapVector  = 32'h0000_0100;

    // Compressed ISA only needs halfword alignment.
    function automatic logic is_misaligned(input logic [1:0] low, input logic c_ext);
        return c_ext ? low[0] : (low != 2'b00);
    endfunction

endpackage

// File: rtl/pc_gen_unit_pc_incr.sv
// Sequential-PC incrementer: pc + 2 for a 16-bit instruction (compressed ISA only), else pc + 4.
module pc_incr #(
    parameter int unsigned XLEN  = 32,
    parameter bit          C_EXT = 1'b0
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            len16_i,
    output logic [XLEN-1:0] pc_plus_o
);

    always_comb begin
        if (C_EXT && len16_i) begin
            pc_plus_o = pc_i + XLEN'(2);
        end else begin
            pc_plus_o = pc_i + XLEN'(4);
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator: PC and MEPC registers, boot/run FSM, next-PC priority mux
// and a fetch valid/ready request towards instruction memory.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DefaultResetVector),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DefaultTrapVector),
    parameter bit              C_EXT        = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    input  logic            instr_len16_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_i,
    input  logic            mret_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            misaligned_o
);

    if (is_misaligned(RESET_VECTOR[1:0], C_EXT)) begin : g_bad_reset_vector
        $error("RESET_VECTOR is not aligned for the configured C_EXT");
    end
    if (is_misaligned(TRAP_VECTOR[1:0], C_EXT)) begin : g_bad_trap_vector
        $error("TRAP_VECTOR is not aligned for the configured C_EXT");
    end

    state_e          state_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic            valid_q;
    logic            mis_q, mis_d;
    logic            target_mis;
    next_sel_e       sel;

    pc_incr #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_pc_incr (
        .pc_i      (pc_q),
        .len16_i   (instr_len16_i),
        .pc_plus_o (pc_plus_o)
    );

    assign target_mis = is_misaligned(redirect_target_i[1:0], C_EXT);

    // Control events outrank stall and handshake; BOOT ignores every input.
    always_comb begin
        sel = SelHold;
        if (state_q == StRun) begin
            if (trap_i) begin
                sel = SelTrap;
            end else if (redirect_valid_i && target_mis) begin
                sel = SelMisalign;
            end else if (mret_i) begin
                sel = SelMret;
            end else if (redirect_valid_i) begin
                sel = SelRedirect;
            end else if (stall_i) begin
                sel = SelHold;
            end else if (valid_q && fetch_ready_i) begin
                sel = SelSeq;
            end
        end
    end

    always_comb begin
        pc_d   = pc_q;
        mepc_d = mepc_q;
        mis_d  = 1'b0;
        unique case (sel)
            SelTrap: begin
                pc_d   = TRAP_VECTOR;
                mepc_d = pc_q;
            end
            SelMisalign: begin
                pc_d   = TRAP_VECTOR;
                mepc_d = pc_q;
                mis_d  = 1'b1;
            end
            SelMret:     pc_d = mepc_q;
            SelRedirect: pc_d = redirect_target_i;
            SelSeq:      pc_d = pc_plus_o;
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_VECTOR;
            mepc_q  <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    state_q <= StRun;
                    valid_q <= 1'b1;
                end
                StRun: begin
                    state_q <= StRun;
                    valid_q <= 1'b1;
                end
                default: begin
                    state_q <= StBoot;
                    valid_q <= 1'b0;
                end
            endcase
            pc_q   <= pc_d;
            mepc_q <= mepc_d;
            mis_q  <= mis_d;
        end
    end

    assign pc_o          = pc_q;
    assign mepc_o        = mepc_q;
    assign fetch_valid_o = valid_q;
    assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: a C_EXT=0 and a C_EXT=1 instance share one stimulus stream.
module tb_pc_gen_unit;

    typedef struct packed {
        logic        stall;
        logic        ready;
        logic        len16;
        logic        redir;
        logic        trap;
        logic        mret;
        logic [31:0] tgt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] mepc;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        fetch_ready_i = 1'b0;
    logic        instr_len16_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_target_i = '0;
    logic        trap_i = 1'b0;
    logic        mret_i = 1'b0;

    logic        fetch_valid_o, misaligned_o;
    logic [31:0] pc_o, pc_plus_o, mepc_o;
    logic        fetch_valid_c, misaligned_c;
    logic [31:0] pc_c, pc_plus_c, mepc_c;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_gen_unit #(.XLEN(32), .C_EXT(1'b0)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .fetch_valid_o     (fetch_valid_o),
        .fetch_ready_i     (fetch_ready_i),
        .instr_len16_i     (instr_len16_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .trap_i            (trap_i),
        .mret_i            (mret_i),
        .pc_o              (pc_o),
        .pc_plus_o         (pc_plus_o),
        .mepc_o            (mepc_o),
        .misaligned_o      (misaligned_o)
    );

    pc_gen_unit #(.XLEN(32), .C_EXT(1'b1)) u_dut_c (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .fetch_valid_o     (fetch_valid_c),
        .fetch_ready_i     (fetch_ready_i),
        .instr_len16_i     (instr_len16_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .trap_i            (trap_i),
        .mret_i            (mret_i),
        .pc_o              (pc_c),
        .pc_plus_o         (pc_plus_c),
        .mepc_o            (mepc_c),
        .misaligned_o      (misaligned_c)
    );

    function automatic stim_t mk_stim(input logic stall, input logic ready, input logic len16,
                                      input logic redir, input logic trap, input logic mret,
                                      input logic [31:0] tgt);
        stim_t s;
        s.stall = stall; s.ready = ready; s.len16 = len16;
        s.redir = redir; s.trap = trap; s.mret = mret; s.tgt = tgt;
        return s;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc, input logic valid,
                                    input logic [31:0] mepc, input logic mis);
        exp_t e;
        e.pc = pc; e.valid = valid; e.mepc = mepc; e.mis = mis;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        stall_i           = s.stall;
        fetch_ready_i     = s.ready;
        instr_len16_i     = s.len16;
        redirect_valid_i  = s.redir;
        trap_i            = s.trap;
        mret_i            = s.mret;
        redirect_target_i = s.tgt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(mk_stim(0, 1, 0, 0, 0, 0, 32'h0));
        #1;
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset pc_o got %h want %h", pc_o, 32'h0); end
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset valid got %b want 0", fetch_valid_o); end
        checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL reset mepc got %h want 0", mepc_o); end
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL reset mis got %b want 0", misaligned_o); end
        checks++; if (pc_c !== 32'h0) begin errors++; $display("FAIL reset pc_c got %h want 0", pc_c); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL boot valid got %b want 0", fetch_valid_o); end
    endtask

    // Runs a table on the C_EXT=0 instance; used by several scenario tasks below.
    task automatic test_sequence(input string tag, input int n, input stim_t st[8], input exp_t ex[8]);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++; if (pc_o !== e.pc) begin errors++; $display("FAIL %s[%0d] pc_o got %h want %h", tag, i, pc_o, e.pc); end
            checks++; if (fetch_valid_o !== e.valid) begin errors++; $display("FAIL %s[%0d] valid got %b want %b", tag, i, fetch_valid_o, e.valid); end
            checks++; if (mepc_o !== e.mepc) begin errors++; $display("FAIL %s[%0d] mepc got %h want %h", tag, i, mepc_o, e.mepc); end
            checks++; if (misaligned_o !== e.mis) begin errors++; $display("FAIL %s[%0d] mis got %b want %b", tag, i, misaligned_o, e.mis); end
        end
    endtask

    task automatic test_boot_seq();
        stim_t st[8]; exp_t ex[8];
        for (int i = 0; i < 8; i++) begin st[i] = '0; ex[i] = '0; end
        st[0] = mk_stim(0, 1, 0, 0, 0, 0, 32'h0); ex[0] = mk_exp(32'h0, 1, 32'h0, 0);
        st[1] = mk_stim(0, 1, 0, 0, 0, 0, 32'h0); ex[1] = mk_exp(32'h4, 1, 32'h0, 0);
        st[2] = mk_stim(0, 1, 0, 0, 0, 0, 32'h0); ex[2] = mk_exp(32'h8, 1, 32'h0, 0);
        st[3] = mk_stim(0, 0, 0, 0, 0, 0, 32'h0); ex[3] = mk_exp(32'h8, 1, 32'h0, 0);
        st[4] = mk_stim(0, 0, 1, 0, 0, 0, 32'h0); ex[4] = mk_exp(32'h8, 1, 32'h0, 0);
        st[5] = mk_stim(0, 0, 0, 0, 0, 0, 32'h0); ex[5] = mk_exp(32'h8, 1, 32'h0, 0);
        st[6] = mk_stim(0, 1, 1, 0, 0, 0, 32'h0); ex[6] = mk_exp(32'hC, 1, 32'h0, 0);
        test_sequence("seq", 7, st, ex);
    endtask

    task automatic test_redirect();
        stim_t st[8]; exp_t ex[8];
        for (int i = 0; i < 8; i++) begin st[i] = '0; ex[i] = '0; end
        st[0] = mk_stim(1, 1, 0, 1, 0, 0, 32'h40); ex[0] = mk_exp(32'h40, 1, 32'h0, 0);
        st[1] = mk_stim(1, 1, 0, 0, 0, 0, 32'h0);  ex[1] = mk_exp(32'h40, 1, 32'h0, 0);
        st[2] = mk_stim(0, 1, 0, 1, 0, 0, 32'h42); ex[2] = mk_exp(32'h100, 1, 32'h40, 1);
        st[3] = mk_stim(0, 0, 0, 0, 0, 0, 32'h0);  ex[3] = mk_exp(32'h100, 1, 32'h40, 0);
        test_sequence("redir", 4, st, ex);
    endtask

    task automatic test_trap_mret();
        stim_t st[8]; exp_t ex[8];
        for (int i = 0; i < 8; i++) begin st[i] = '0; ex[i] = '0; end
        st[0] = mk_stim(0, 0, 0, 1, 0, 0, 32'h20); ex[0] = mk_exp(32'h20, 1, 32'h40, 0);
        st[1] = mk_stim(1, 1, 0, 0, 1, 0, 32'h0);  ex[1] = mk_exp(32'h100, 1, 32'h20, 0);
        st[2] = mk_stim(0, 0, 0, 0, 0, 1, 32'h0);  ex[2] = mk_exp(32'h20, 1, 32'h20, 0);
        st[3] = mk_stim(0, 1, 0, 0, 0, 0, 32'h0);  ex[3] = mk_exp(32'h24, 1, 32'h20, 0);
        st[4] = mk_stim(0, 1, 0, 0, 1, 1, 32'h0);  ex[4] = mk_exp(32'h100, 1, 32'h24, 0);
        st[5] = mk_stim(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC); ex[5] = mk_exp(32'hFFFF_FFFC, 1, 32'h24, 0);
        st[6] = mk_stim(0, 1, 0, 0, 0, 0, 32'h0);  ex[6] = mk_exp(32'h0, 1, 32'h24, 0);
        test_sequence("trap", 7, st, ex);
    endtask

    task automatic test_reset_mid();
        stim_t st[8]; exp_t ex[8];
        for (int i = 0; i < 8; i++) begin st[i] = '0; ex[i] = '0; end
        apply(mk_stim(0, 1, 0, 0, 0, 0, 32'h0));
        #2;
        reset = 1'b1;
        #1;
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL midrst pc_o got %h want 0", pc_o); end
        checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL midrst mepc got %h want 0", mepc_o); end
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL midrst valid got %b want 0", fetch_valid_o); end
        @(negedge clk);
        reset = 1'b0;
        // BOOT must ignore trap, misaligned redirect and mret.
        st[0] = mk_stim(0, 1, 0, 1, 1, 1, 32'h42); ex[0] = mk_exp(32'h0, 1, 32'h0, 0);
        st[1] = mk_stim(0, 1, 0, 0, 0, 0, 32'h0);  ex[1] = mk_exp(32'h4, 1, 32'h0, 0);
        test_sequence("boot", 2, st, ex);
    endtask

    task automatic test_cext();
        stim_t st[7]; exp_t ex[7]; logic [31:0] plus[7]; exp_t e;
        reset = 1'b1;
        apply(mk_stim(0, 0, 0, 0, 0, 0, 32'h0));
        @(negedge clk);
        reset = 1'b0;
        st[0] = mk_stim(0, 0, 0, 0, 0, 0, 32'h0);  ex[0] = mk_exp(32'h0, 1, 32'h0, 0);   plus[0] = 32'h4;
        st[1] = mk_stim(0, 0, 0, 1, 0, 0, 32'h10); ex[1] = mk_exp(32'h10, 1, 32'h0, 0);  plus[1] = 32'h4;
        st[2] = mk_stim(0, 1, 1, 0, 0, 0, 32'h0);  ex[2] = mk_exp(32'h12, 1, 32'h0, 0);  plus[2] = 32'h12;
        st[3] = mk_stim(0, 1, 0, 0, 0, 0, 32'h0);  ex[3] = mk_exp(32'h16, 1, 32'h0, 0);  plus[3] = 32'h16;
        st[4] = mk_stim(0, 0, 0, 1, 0, 0, 32'h43); ex[4] = mk_exp(32'h100, 1, 32'h16, 1); plus[4] = 32'h1A;
        st[5] = mk_stim(0, 0, 0, 1, 0, 0, 32'h42); ex[5] = mk_exp(32'h42, 1, 32'h16, 0); plus[5] = 32'h104;
        st[6] = mk_stim(0, 0, 1, 0, 0, 0, 32'h0);  ex[6] = mk_exp(32'h42, 1, 32'h16, 0); plus[6] = 32'h44;
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            #1;
            checks++; if (pc_plus_c !== plus[i]) begin errors++; $display("FAIL cext[%0d] pc_plus got %h want %h", i, pc_plus_c, plus[i]); end
            if (i == 2) begin
                checks++; if (pc_plus_o !== 32'h14) begin errors++; $display("FAIL noc pc_plus got %h want 00000014", pc_plus_o); end
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++; if (pc_c !== e.pc) begin errors++; $display("FAIL cext[%0d] pc got %h want %h", i, pc_c, e.pc); end
            checks++; if (fetch_valid_c !== e.valid) begin errors++; $display("FAIL cext[%0d] valid got %b want %b", i, fetch_valid_c, e.valid); end
            checks++; if (mepc_c !== e.mepc) begin errors++; $display("FAIL cext[%0d] mepc got %h want %h", i, mepc_c, e.mepc); end
            checks++; if (misaligned_c !== e.mis) begin errors++; $display("FAIL cext[%0d] mis got %b want %b", i, misaligned_c, e.mis); end
        end
    endtask

    initial begin
        test_reset();
        test_boot_seq();
        test_redirect();
        test_trap_mret();
        test_reset_mid();
        test_cext();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
